// File: rtl/mux_arbiter_pkg.sv
// Shared constants, FSM state type and a one-hot helper for the
// round-robin mux arbiter.
package mux_arbiter_pkg;

   localparam int NREQ   = 8;
   localparam int DATA_W = 4;
   localparam int SEL_W  = 3;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   // Expand a requester index into a one-hot requester vector.
   function automatic logic [NREQ-1:0] onehot(input logic [SEL_W-1:0] idx);
      logic [NREQ-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/rr_pick8.sv
// Combinational round-robin picker for eight requesters: the first set
// bit of req_masked found when scanning upward from ptr (wrapping at 7)
// wins. The vector is rotated so that ptr lands on bit 0, the lowest set
// bit of the rotated vector is located, and ptr is added back.
module rr_pick8 (
   input  logic [7:0] req_masked,
   input  logic [2:0] ptr,
   output logic       any,
   output logic [2:0] idx
);

   logic [7:0] rot;
   logic [2:0] off;

   // Rotate right by ptr, then priority-encode the lowest set bit.
   always_comb begin
      rot = (req_masked >> ptr) | (req_masked << (4'd8 - {1'b0, ptr}));
      off = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (rot[i]) begin
            off = 3'(i);
         end
      end
      any = |req_masked;
      idx = ptr + off;
   end

endmodule

// File: rtl/mux_arbiter.sv
// Round-robin N:1 data mux with a valid/ready output handshake.
// Requesters hold req until they see their one-cycle ack pulse. A grant
// captures the winner's data into out_data and holds it until the
// downstream accepts; on acceptance the next winner (if any other
// requester is waiting) is presented on the very next cycle.
// Optional feature: define MUX_ARBITER_LOCK_EN to add the lock input,
// which lets the current owner keep the grant across handshakes.
module mux_arbiter #(
   parameter int NREQ   = 8,
   parameter int DATA_W = 4,
   parameter int SEL_W  = 3
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NREQ-1:0]        req,
   input  logic [NREQ*DATA_W-1:0] data,
   input  logic                   out_ready,
`ifdef MUX_ARBITER_LOCK_EN
   input  logic [NREQ-1:0]        lock,
`endif
   output logic                   out_valid,
   output logic [DATA_W-1:0]      out_data,
   output logic [SEL_W-1:0]       sel,
   output logic [NREQ-1:0]        ack,
   output logic                   busy
);

   import mux_arbiter_pkg::*;

   state_t              state;
   state_t              state_nxt;
   logic [SEL_W-1:0]    ptr;
   logic [SEL_W-1:0]    ptr_nxt;
   logic [SEL_W-1:0]    sel_nxt;
   logic [DATA_W-1:0]   data_nxt;
   logic                valid_nxt;
   logic [NREQ-1:0]     ack_nxt;

   logic [NREQ-1:0]     sel_onehot;
   logic [NREQ-1:0]     pick_req;
   logic [SEL_W-1:0]    pick_ptr;
   logic [SEL_W-1:0]    pick_idx;
   logic                pick_any;
   logic                relock;

   // Extract one requester's lane from the packed data bus.
   function automatic logic [DATA_W-1:0] lane(
      input logic [NREQ*DATA_W-1:0] bus,
      input logic [SEL_W-1:0]       idx
   );
      return bus[idx*DATA_W +: DATA_W];
   endfunction

   assign sel_onehot = onehot(sel);
   assign busy       = (state == GRANT);

`ifdef MUX_ARBITER_LOCK_EN
   // A locked owner that still requests keeps the grant at handshake.
   assign relock = lock[sel] & req[sel];
`else
   assign relock = 1'b0;
`endif

   // Picker inputs: in IDLE search from ptr over all requests; in GRANT
   // prepare the back-to-back winner, searching from sel+1 with the
   // current owner masked out so it cannot win twice in a row.
   always_comb begin
      if (state == GRANT) begin
         pick_req = req & ~sel_onehot;
         pick_ptr = sel + SEL_W'(1);
      end else begin
         pick_req = req;
         pick_ptr = ptr;
      end
   end

   rr_pick8 u_pick (
      .req_masked (pick_req),
      .ptr        (pick_ptr),
      .any        (pick_any),
      .idx        (pick_idx)
   );

   // Next-state and next-output logic for the IDLE/GRANT machine.
   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      sel_nxt   = sel;
      data_nxt  = out_data;
      valid_nxt = out_valid;
      ack_nxt   = '0;
      case (state)
         IDLE: begin
            if (pick_any) begin
               state_nxt = GRANT;
               sel_nxt   = pick_idx;
               data_nxt  = lane(data, pick_idx);
               valid_nxt = 1'b1;
            end else begin
               sel_nxt   = '0;
               data_nxt  = '0;
               valid_nxt = 1'b0;
            end
         end
         GRANT: begin
            // Without out_ready everything holds; data/req changes are ignored.
            if (out_ready) begin
               ack_nxt = sel_onehot;
               if (relock) begin
                  // Same owner again: fresh data, pointer stays put.
                  data_nxt = lane(data, sel);
               end else begin
                  ptr_nxt = sel + SEL_W'(1);
                  if (pick_any) begin
                     sel_nxt  = pick_idx;
                     data_nxt = lane(data, pick_idx);
                  end else begin
                     state_nxt = IDLE;
                     sel_nxt   = '0;
                     data_nxt  = '0;
                     valid_nxt = 1'b0;
                  end
               end
            end
         end
         default: begin
            state_nxt = IDLE;
            sel_nxt   = '0;
            data_nxt  = '0;
            valid_nxt = 1'b0;
         end
      endcase
   end

   // State and output registers; reset aborts any grant without an ack.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         ptr       <= '0;
         sel       <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
         ack       <= '0;
      end else begin
         state     <= state_nxt;
         ptr       <= ptr_nxt;
         sel       <= sel_nxt;
         out_data  <= data_nxt;
         out_valid <= valid_nxt;
         ack       <= ack_nxt;
      end
   end

   // An ack is a single requester and only follows an accepted transfer.
   ack_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(ack));
   ack_after_xfer: assert property (@(posedge clk) disable iff (!rst_n)
      (ack != '0) |-> $past(out_valid && out_ready && rst_n));

endmodule

// File: tb/tb_mux_arbiter.sv
// Scoreboard bench for mux_arbiter. Stimulus (directed scenarios plus
// randomized traffic) feeds a transaction-level reference model that
// pushes every expected grant into a queue; an independent monitor pops
// and compares whenever the DUT completes a transfer, and checks the
// per-cycle valid/busy/idle/ack behaviour.
module tb_mux_arbiter;

`ifdef MUX_ARBITER_LOCK_EN
   localparam bit LOCK_ON = 1'b1;
`else
   localparam bit LOCK_ON = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  req;
   logic [31:0] data;
   logic        out_ready;
`ifdef MUX_ARBITER_LOCK_EN
   logic [7:0]  lock;
`endif
   logic        out_valid;
   logic [3:0]  out_data;
   logic [2:0]  sel;
   logic [7:0]  ack;
   logic        busy;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   mux_arbiter dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .data      (data),
      .out_ready (out_ready),
`ifdef MUX_ARBITER_LOCK_EN
      .lock      (lock),
`endif
      .out_valid (out_valid),
      .out_data  (out_data),
      .sel       (sel),
      .ack       (ack),
      .busy      (busy)
   );

   typedef struct packed {
      logic [2:0] idx;
      logic [3:0] dat;
   } grant_t;

   grant_t gq[$];     // expected grants, in completion order
   logic   ev_q[$];   // expected out_valid after each edge

   // stimulus state
   logic [7:0] pend;
   logic [3:0] dval [8];
   logic       rdy;
   logic       rstv;
   logic [7:0] lockv;
   bit         rnd;
   bit         auto_drop;

   // reference model state
   int m_ptr;
   bit m_busy;
   int m_sel;
   int drop_idx;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // First requesting index found scanning start, start+1, ... mod 8.
   function automatic int rr_first(input logic [7:0] r, input int start);
      for (int i = 0; i < 8; i++) begin
         if (r[(start + i) % 8]) return (start + i) % 8;
      end
      return -1;
   endfunction

   // Predict what the coming clock edge does with the inputs just driven.
   task automatic model_step();
      logic [7:0] others;
      int k;
      drop_idx = -1;
      if (!rstv) begin
         m_ptr  = 0;
         m_busy = 1'b0;
         m_sel  = 0;
         gq.delete();
      end else if (!m_busy) begin
         k = rr_first(pend, m_ptr);
         if (k >= 0) begin
            m_busy = 1'b1;
            m_sel  = k;
            gq.push_back('{idx: 3'(k), dat: dval[k]});
         end
      end else if (rdy) begin
         if (LOCK_ON && lockv[m_sel] && pend[m_sel]) begin
            gq.push_back('{idx: 3'(m_sel), dat: dval[m_sel]});
         end else begin
            drop_idx = m_sel;
            m_ptr    = (m_sel + 1) % 8;
            others   = pend;
            others[m_sel] = 1'b0;
            k = rr_first(others, m_ptr);
            if (k >= 0) begin
               m_sel = k;
               gq.push_back('{idx: 3'(k), dat: dval[k]});
            end else begin
               m_busy = 1'b0;
            end
         end
      end
      ev_q.push_back(m_busy);
   endtask

   // One clock of stimulus, driven just after the falling edge.
   task automatic cycle();
      @(negedge clk);
      #1;
      if (auto_drop && drop_idx >= 0) pend[drop_idx] = 1'b0;
      if (rnd) begin
         for (int i = 0; i < 8; i++) begin
            dval[i] = 4'($urandom);
            if (!pend[i] && $urandom_range(0, 99) < 30) pend[i] = 1'b1;
         end
         rdy   = ($urandom_range(0, 99) < 70);
         lockv = 8'($urandom) & 8'($urandom);
         if (m_busy && $urandom_range(0, 99) < 8) pend[m_sel] = 1'b0;
         rstv  = ($urandom_range(0, 199) != 0);
      end
      rst_n     = rstv;
      req       = pend;
      out_ready = rdy;
`ifdef MUX_ARBITER_LOCK_EN
      lock      = lockv;
`endif
      for (int i = 0; i < 8; i++) data[i*4 +: 4] = dval[i];
      model_step();
   endtask

   task automatic do_reset();
      rstv = 1'b0;
      cycle();
      rstv = 1'b1;
   endtask

   // Monitor: per-cycle state checks plus scoreboard pop on each transfer.
   initial begin : monitor
      logic       pv;
      logic [2:0] ps;
      logic [3:0] pd;
      logic       e;
      grant_t     g;
      pv = 1'b0;
      ps = '0;
      pd = '0;
      forever begin
         @(posedge clk);
         #1;
         if (ev_q.size() > 0) begin
            e = ev_q.pop_front();
            chk("out_valid", 32'(out_valid), 32'(e));
            chk("busy", 32'(busy), 32'(e));
            if (!e) begin
               chk("idle_sel", 32'(sel), 32'd0);
               chk("idle_data", 32'(out_data), 32'd0);
            end
            if (rst_n && pv && out_ready) begin
               if (gq.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL grant_queue: transfer of sel %0d with nothing expected", ps);
               end else begin
                  g = gq.pop_front();
                  chk("xfer_sel", 32'(ps), 32'(g.idx));
                  chk("xfer_data", 32'(pd), 32'(g.dat));
                  chk("ack_pulse", 32'(ack), 32'(8'd1 << g.idx));
               end
            end else begin
               chk("ack_quiet", 32'(ack), 32'd0);
            end
         end
         pv = out_valid;
         ps = sel;
         pd = out_data;
      end
   end

   initial begin : stimulus
      rst_n = 1'b0;
      req = '0;
      data = '0;
      out_ready = 1'b0;
`ifdef MUX_ARBITER_LOCK_EN
      lock = '0;
`endif
      rnd = 1'b0;
      auto_drop = 1'b1;
      rstv = 1'b0;
      pend = '0;
      rdy = 1'b0;
      lockv = '0;
      for (int i = 0; i < 8; i++) dval[i] = '0;
      m_ptr = 0;
      m_busy = 1'b0;
      m_sel = 0;
      drop_idx = -1;

      repeat (3) cycle();

      // single requester 2, immediate acceptance
      rstv = 1'b1;
      pend = 8'b0000_0100;
      dval[2] = 4'hA;
      rdy = 1'b1;
      repeat (5) cycle();

      // all requesters held high: 0..7,0 back to back
      do_reset();
      auto_drop = 1'b0;
      pend = 8'hFF;
      for (int i = 0; i < 8; i++) dval[i] = 4'(i + 3);
      repeat (10) cycle();
      pend = '0;
      auto_drop = 1'b1;
      repeat (3) cycle();

      // grant 5 stalled while its data keeps changing
      do_reset();
      pend = 8'b0010_0000;
      dval[5] = 4'h3;
      rdy = 1'b0;
      cycle();
      repeat (4) begin
         dval[5] = 4'($urandom);
         cycle();
      end
      rdy = 1'b1;
      repeat (3) cycle();

      // pointer at 7 wraps to 0
      do_reset();
      pend = 8'b0100_0000;
      repeat (3) cycle();
      pend = 8'b1000_0001;
      dval[7] = 4'h7;
      dval[0] = 4'hE;
      repeat (4) cycle();

      // reset aborts a stalled grant; pointer restarts at 0
      do_reset();
      pend = 8'b0000_1000;
      rdy = 1'b0;
      repeat (2) cycle();
      rstv = 1'b0;
      cycle();
      rstv = 1'b1;
      pend = 8'b0000_1001;
      rdy = 1'b1;
      repeat (4) cycle();

`ifdef MUX_ARBITER_LOCK_EN
      // locked owner 4 keeps the grant until lock drops
      do_reset();
      pend = 8'b0000_0100;
      repeat (3) cycle();
      pend = 8'b0001_0010;
      lockv = 8'b0001_0000;
      repeat (4) cycle();
      lockv = '0;
      repeat (4) cycle();
`endif

      // randomized traffic with stalls, withdrawals and occasional reset
      rnd = 1'b1;
      repeat (3000) cycle();

      // drain
      rnd = 1'b0;
      rstv = 1'b1;
      pend = '0;
      rdy = 1'b1;
      lockv = '0;
      repeat (5) cycle();
      @(posedge clk);
      #2;
      chk("grants_left", 32'(gq.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
